sw_run_controller: RTL
======================

# sw_run_controller

Board-level run sequencer that sits between the DE2-115 push-buttons/switches and the Smith-Waterman FPGA wrapper. It debounces the "load T" and "start" buttons and issues exactly one single-cycle `set_t` / `start_cal` pulse per press, only in legal order. It freezes the scoring parameters for the whole run, waits for the wrapper's result under a watchdog, and holds the last score for display.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a button level change (≥2).
- `TIMEOUT_W`, default 24: watchdog counter width; expiry at 2^TIMEOUT_W−1 cycles.
- `RESULT_W`, default 18: score width.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_btn_set`  in  1  raw "load T" button, active-high, asynchronous to `clk`.
- `i_btn_start`  in  1  raw "start" button, active-high, asynchronous.
- `i_match`, `i_mismatch`, `i_minusAlpha`, `i_minusBeta`  in  4 each  live switch values.
- `o_match`, `o_mismatch`, `o_minusAlpha`, `o_minusBeta`  out  4 each  frozen parameters to the wrapper.
- `o_set_t`  out  1  one-cycle pulse, load target sequence.
- `o_start_cal`  out  1  one-cycle pulse, start calculation.
- `i_busy`  in  1  wrapper busy.
- `i_result`  in  RESULT_W  wrapper score.
- `i_valid`  in  1  one-cycle result strobe.
- `o_score`  out  RESULT_W  last captured score, held.
- `o_score_valid`  out  1  `o_score` belongs to the most recent completed run.
- `o_is_set`  out  1  a target sequence has been loaded since reset.
- `o_run_cnt`  out  8  completed runs, saturates at 255.
- `o_timeout`  out  1  sticky watchdog flag.
- `o_state`  out  3  FSM state code for LEDs.

## Operation
- Each button passes through a 2-FF synchronizer and then a debouncer. The debounced level changes only after the synced level has differed from it for DEB_CYCLES consecutive cycles; any agreeing cycle clears the counter.
- A press event is the debounced rising edge, one cycle wide. Releases generate no event.
- FSM states and codes:
  - IDLE=0: waiting for a set press. Start presses are ignored.
  - SETP=1: `o_set_t`=1 for this cycle only. Next state is LOAD.
  - LOAD=2: wait for `i_busy`=0, then go to READY and set `o_is_set`.
  - READY=3: a set press goes to SETP (reload T). Otherwise a start press goes to STARTP. Set wins if both occur in the same cycle.
  - STARTP=4: `o_start_cal`=1 for this cycle only. The four parameters are latched on entry. `o_score_valid` is cleared. Next state is RUN.
  - RUN=5: on `i_valid`, capture `i_result` into `o_score`, set `o_score_valid`, increment `o_run_cnt` (saturating), and go to READY.
- Presses arriving in SETP/LOAD/STARTP/RUN are dropped, not queued.
- Watchdog:
  - Cleared on entry to LOAD and RUN; increments every cycle in those states.
  - At all-ones: set `o_timeout` (sticky until reset), go to READY, and leave `o_score` and `o_score_valid` unchanged (valid stays 0 after a RUN timeout).
- In RUN, `i_valid` takes priority over watchdog expiry in the same cycle.
- `i_valid` outside RUN is ignored.
- Parameter outputs change only at STARTP entry. Switch changes during RUN have no effect.

## Timing
- Reset:
  - State IDLE.
  - Every output 0: pulses, params, `o_score`, flags, `o_run_cnt`, `o_state`.
  - Synchronizers, debouncers and watchdog cleared.
  - Reset mid-RUN or mid-LOAD aborts the operation; T must be reloaded.
- Press latency: with a raw press first sampled at edge 0, the debounced level rises at edge DEB_CYCLES+1. The FSM enters SETP/STARTP at edge DEB_CYCLES+2, so the pulse is high for the following cycle.
- LOAD samples `i_busy` from the cycle after the `o_set_t` pulse. The wrapper must raise busy by then or LOAD exits immediately; this is accepted behaviour.
- Result capture: `i_valid` high in cycle n → `o_score`/`o_score_valid`/`o_run_cnt` updated and `o_state`=READY from cycle n+1.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset, then press start (held 40 cycles, DEB_CYCLES=16) → no `o_start_cal`; `o_state` stays 0; `o_is_set`=0.
- Press set with bounce (toggling every 3 cycles for 30 cycles, then steady high) → exactly one `o_set_t` pulse, 18 cycles after the steady level is sampled; busy high 10 cycles then low → `o_is_set`=1, state READY(3).
- From READY with switches 2/1/3/1, press start, change switches to F/F/F/F during RUN, drive `i_valid` with `i_result`=18'd37 → one `o_start_cal`; params stay 2/1/3/1; `o_score`=37; `o_score_valid`=1; `o_run_cnt`=1.
- TIMEOUT_W=6: start with no `i_valid` → after 63 RUN cycles `o_timeout`=1, state READY, `o_score_valid`=0; a later valid run still captures its score and `o_timeout` remains 1.
- Run 256 completed runs → `o_run_cnt` saturates at 255; set and start press events in the same cycle in READY → only `o_set_t` pulses.
- Assert `rst` while in RUN → all outputs 0 immediately (asynchronously); a start press afterwards is ignored until a set press.

Source files
------------

// File: rtl/sw_run_controller.sv
// Run sequencer between DE2-115 buttons/switches and the Smith-Waterman wrapper:
// debounced press events, load/start pulses, frozen parameters, watchdog, score hold.
module sw_run_controller #(
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT_W  = 24,
  parameter int RESULT_W   = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_btn_set,
  input  logic                i_btn_start,
  input  logic [3:0]          i_match,
  input  logic [3:0]          i_mismatch,
  input  logic [3:0]          i_minusAlpha,
  input  logic [3:0]          i_minusBeta,
  output logic [3:0]          o_match,
  output logic [3:0]          o_mismatch,
  output logic [3:0]          o_minusAlpha,
  output logic [3:0]          o_minusBeta,
  output logic                o_set_t,
  output logic                o_start_cal,
  input  logic                i_busy,
  input  logic [RESULT_W-1:0] i_result,
  input  logic                i_valid,
  output logic [RESULT_W-1:0] o_score,
  output logic                o_score_valid,
  output logic                o_is_set,
  output logic [7:0]          o_run_cnt,
  output logic                o_timeout,
  output logic [2:0]          o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETP   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_STARTP = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;

  localparam int              CNT_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] press;  // bit 0: set, bit 1: start
  assign raw = {i_btn_start, i_btn_set};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             s1, s2, lvl, lvl_q;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, giving a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_q <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[g];
        s2    <= s1;
        lvl_q <= lvl;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[g] = lvl & ~lvl_q;
  end

  logic [2:0]           state;
  logic [TIMEOUT_W-1:0] wd;

  // Pulses are pure decodes of the state register, so no input reaches an output combinationally.
  assign o_state     = state;
  assign o_set_t     = (state == S_SETP);
  assign o_start_cal = (state == S_STARTP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wd            <= '0;
      o_match       <= '0;
      o_mismatch    <= '0;
      o_minusAlpha  <= '0;
      o_minusBeta   <= '0;
      o_score       <= '0;
      o_score_valid <= 1'b0;
      o_is_set      <= 1'b0;
      o_run_cnt     <= '0;
      o_timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press[0]) state <= S_SETP;
        end
        S_SETP: begin
          state <= S_LOAD;
          wd    <= '0;
        end
        S_LOAD: begin
          if (!i_busy) begin
            state    <= S_READY;
            o_is_set <= 1'b1;
          end else if (&wd) begin
            state     <= S_READY;
            o_timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_READY: begin
          if (press[0]) begin
            state <= S_SETP;
          end else if (press[1]) begin
            state         <= S_STARTP;
            o_match       <= i_match;
            o_mismatch    <= i_mismatch;
            o_minusAlpha  <= i_minusAlpha;
            o_minusBeta   <= i_minusBeta;
            o_score_valid <= 1'b0;
          end
        end
        S_STARTP: begin
          state <= S_RUN;
          wd    <= '0;
        end
        S_RUN: begin
          if (i_valid) begin
            state         <= S_READY;
            o_score       <= i_result;
            o_score_valid <= 1'b1;
            if (o_run_cnt != 8'hFF) o_run_cnt <= o_run_cnt + 1'b1;
          end else if (&wd) begin
            state     <= S_READY;
            o_timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
